// File: rtl/load_store_unit.sv
// Load/store unit: accepts one operation from execute, performs at most one data-memory
// access with a bounded ack wait, aligns and extends load data, and retires to the register file.
module load_store_unit #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  input  logic        wb_reg,
  input  logic [4:0]  rd_num,
  input  logic [31:0] alu_out,
  input  logic [31:0] store_data,
  output logic        ready,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_enable,
  output logic [4:0]  wb_rd_num,
  output logic [31:0] wb_rd_data,
  output logic        done,
  output logic        misalign,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, MEM, RETIRE} state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  state_t      state, state_nx;
  logic [7:0]  wait_cnt;
  logic        accept, is_load, is_store, is_mem, misaligned, wait_expired;
  logic [3:0]  be_nx;
  logic [31:0] wdata_nx;

  // Operation captured at acceptance; later input changes have no effect.
  logic        r_load, r_we, r_mis, r_to, r_wb;
  logic [2:0]  r_func3;
  logic [4:0]  r_rd;
  logic [31:0] r_addr, r_wdata, r_result;
  logic [3:0]  r_be;

  assign accept       = valid && (state == IDLE);
  assign is_load      = (opcode == OP_LOAD);
  assign is_store     = (opcode == OP_STORE);
  assign is_mem       = is_load || is_store;
  assign wait_expired = (state == MEM) && !dmem_ack && (wait_cnt == LAST_WAIT);

  function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] word);
    logic [31:0] lane;
    logic [31:0] res;
    lane = word >> {off, 3'b000};
    case (f3)
      3'b000:  res = {{24{lane[7]}}, lane[7:0]};
      3'b100:  res = {24'b0, lane[7:0]};
      3'b001:  res = {{16{lane[15]}}, lane[15:0]};
      3'b101:  res = {16'b0, lane[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

  // Access-size decode: alignment check, store lanes and replicated write data.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    misaligned = 1'b0;
    be_nx      = 4'b1111;
    wdata_nx   = store_data;
    case (func3[1:0])
      2'b00: if (is_store) begin
        be_nx    = 4'b0001 << alu_out[1:0];
        wdata_nx = {4{store_data[7:0]}};
      end
      2'b01: begin
        misaligned = alu_out[0];
        if (is_store) begin
          be_nx    = 4'b0011 << alu_out[1:0];
          wdata_nx = {2{store_data[15:0]}};
        end
      end
      2'b10:   misaligned = |alu_out[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = (is_mem && !misaligned) ? MEM : RETIRE;
      MEM:     if (dmem_ack || wait_expired) state_nx = RETIRE;
      RETIRE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: the captured operation is reset as well, because it drives outputs that read zero in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
      r_load   <= 1'b0;
      r_we     <= 1'b0;
      r_mis    <= 1'b0;
      r_to     <= 1'b0;
      r_wb     <= 1'b0;
      r_func3  <= '0;
      r_rd     <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_be     <= '0;
      r_result <= '0;
    end else begin
      if (state == MEM && !dmem_ack) wait_cnt <= wait_cnt + 8'd1;
      else                           wait_cnt <= '0;

      if (accept) begin
        r_load   <= is_load;
        r_we     <= is_store;
        r_mis    <= is_mem && misaligned;
        r_to     <= 1'b0;
        r_wb     <= is_mem ? (is_load && !misaligned) : wb_reg;
        r_func3  <= func3;
        r_rd     <= rd_num;
        r_addr   <= alu_out;
        r_wdata  <= wdata_nx;
        r_be     <= be_nx;
        r_result <= alu_out;
      end else if (state == MEM) begin
        // An ack on the last allowed wait cycle wins over the timeout.
        if (dmem_ack) begin
          if (r_load) r_result <= load_extend(r_func3, r_addr[1:0], dmem_rdata);
        end else if (wait_expired) begin
          r_to <= 1'b1;
          r_wb <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    ready      = (state == IDLE);
    dmem_req   = (state == MEM);
    done       = (state == RETIRE);
    dmem_we    = dmem_req && r_we;
    dmem_addr  = dmem_req ? {r_addr[31:2], 2'b00} : '0;
    dmem_wdata = dmem_req ? r_wdata : '0;
    dmem_be    = dmem_req ? r_be : '0;
    misalign   = done && r_mis;
    timeout    = done && r_to;
    wb_enable  = done && r_wb && (r_rd != 5'd0);
    wb_rd_num  = r_rd;
    wb_rd_data = r_result;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: reset values, a table of single-cycle retirements,
// directed memory sequences, and randomized operations checked against a behavioural model.
module tb_load_store_unit;

  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic        wb_reg;
  logic [4:0]  rd_num;
  logic [31:0] alu_out, store_data;
  logic        ready, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_enable, done, misalign, timeout;
  logic [4:0]  wb_rd_num;
  logic [31:0] wb_rd_data;

  int n_vec  = 0;
  int n_fail = 0;
  bit ack_noise = 1'b0;

  always #5 clk = ~clk;

  load_store_unit #(.MAX_WAIT(16)) dut (
    .clk(clk), .rst(rst), .valid(valid), .opcode(opcode), .func3(func3), .wb_reg(wb_reg),
    .rd_num(rd_num), .alu_out(alu_out), .store_data(store_data), .ready(ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_enable(wb_enable),
    .wb_rd_num(wb_rd_num), .wb_rd_data(wb_rd_data), .done(done), .misalign(misalign),
    .timeout(timeout)
  );

  typedef struct {
    int          latency;
    int          req_cycles;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic        unstable;
    logic        ready_at_start;
    logic        done;
    logic        wb_en;
    logic [4:0]  wb_num;
    logic [31:0] wb_data;
    logic        mis;
    logic        to;
    logic        after_done;
    logic        after_ready;
  } obs_t;

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        wbr;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic        exp_wb;
    logic [31:0] exp_data;
    logic        exp_mis;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one operation, play the memory side, and record what the DUT did until retirement.
  task automatic exec_op(input logic [6:0] opc, input logic [2:0] f3, input logic wbr,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] sd,
                         input int ack_at, input logic [31:0] rdata, output obs_t o);
    int cyc;
    o = '{default: 0};
    @(negedge clk);
    o.ready_at_start = ready;
    valid = 1'b1; opcode = opc; func3 = f3; wb_reg = wbr; rd_num = rd;
    alu_out = alu; store_data = sd;
    dmem_ack = ack_noise ? 1'($urandom) : 1'b0;
    @(negedge clk);
    valid = 1'b0; opcode = 7'($urandom); func3 = 3'($urandom); wb_reg = 1'($urandom);
    rd_num = 5'($urandom); alu_out = $urandom; store_data = $urandom;
    cyc = 1;
    while (!done && cyc <= 300) begin
      if (dmem_req) begin
        o.req_cycles++;
        if (o.req_cycles == 1) begin
          o.addr = dmem_addr; o.be = dmem_be; o.wdata = dmem_wdata; o.we = dmem_we;
        end else if (dmem_addr !== o.addr || dmem_be !== o.be ||
                     dmem_wdata !== o.wdata || dmem_we !== o.we) begin
          o.unstable = 1'b1;
        end
        dmem_ack   = (o.req_cycles == ack_at);
        dmem_rdata = dmem_ack ? rdata : $urandom;
      end else begin
        dmem_ack = ack_noise ? 1'($urandom) : 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    o.latency = cyc; o.done = done; o.wb_en = wb_enable; o.wb_num = wb_rd_num;
    o.wb_data = wb_rd_data; o.mis = misalign; o.to = timeout;
    dmem_ack = 1'b0;
    @(negedge clk);
    o.after_done = done; o.after_ready = ready;
  endtask

  // Reference behaviour derived from the operation's rules, with MAX_WAIT = 16.
  task automatic model(input logic [6:0] opc, input logic [2:0] f3, input logic wbr,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] sd,
                       input int ack_at, input logic [31:0] rdata, output obs_t e,
                       output bit chk_data);
    int unsigned off, sz, lane, b, h;
    int v;
    bit ld, st, mis;
    e = '{default: 0};
    ld  = (opc == OP_LOAD);
    st  = (opc == OP_STORE);
    off = alu % 4;
    sz  = f3 % 4;
    mis = (sz == 3) || (sz == 1 && off % 2 == 1) || (sz == 2 && off != 0);
    e.ready_at_start = 1'b1; e.done = 1'b1; e.after_ready = 1'b1; e.wb_num = rd;
    chk_data = 1'b0;
    if (!ld && !st) begin
      e.latency = 1; e.wb_en = wbr && (rd != 0); e.wb_data = alu; chk_data = 1'b1;
    end else if (mis) begin
      e.latency = 1; e.mis = 1'b1;
    end else begin
      e.addr = alu - off;
      e.we   = st;
      e.be   = !st ? 4'd15 : (sz == 0) ? 4'(1 << off) : (sz == 1) ? 4'(3 << off) : 4'd15;
      e.wdata = (sz == 0) ? (sd % 256) * 32'h01010101 :
                (sz == 1) ? (sd % 65536) * 32'h00010001 : sd;
      if (ack_at >= 1 && ack_at <= 16) begin
        e.req_cycles = ack_at; e.latency = ack_at + 1;
        if (ld) begin
          lane = rdata / (1 << (8 * off));
          b = lane % 256;
          h = lane % 65536;
          case (f3)
            3'd0: begin v = int'(b); if (v >= 128) v -= 256; e.wb_data = 32'(v); end
            3'd1: begin v = int'(h); if (v >= 32768) v -= 65536; e.wb_data = 32'(v); end
            3'd4: e.wb_data = b;
            3'd5: e.wb_data = h;
            default: e.wb_data = rdata;
          endcase
          e.wb_en = (rd != 0); chk_data = 1'b1;
        end
      end else begin
        e.req_cycles = 16; e.latency = 17; e.to = 1'b1;
      end
    end
  endtask

  task automatic compare(input string tag, input obs_t o, input obs_t e, input bit chk_data);
    check({tag, " ready_at_issue"}, o.ready_at_start, e.ready_at_start);
    check({tag, " latency"}, o.latency, e.latency);
    check({tag, " req_cycles"}, o.req_cycles, e.req_cycles);
    check({tag, " done"}, o.done, e.done);
    check({tag, " misalign"}, o.mis, e.mis);
    check({tag, " timeout"}, o.to, e.to);
    check({tag, " wb_enable"}, o.wb_en, e.wb_en);
    check({tag, " wb_rd_num"}, o.wb_num, e.wb_num);
    if (e.req_cycles > 0) begin
      check({tag, " dmem_addr"}, o.addr, e.addr);
      check({tag, " dmem_be"}, o.be, e.be);
      check({tag, " dmem_we"}, o.we, e.we);
      check({tag, " req_stable"}, o.unstable, 1'b0);
      if (e.we) check({tag, " dmem_wdata"}, o.wdata, e.wdata);
    end
    if (chk_data) check({tag, " wb_rd_data"}, o.wb_data, e.wb_data);
    check({tag, " done_pulse"}, o.after_done, 1'b0);
    check({tag, " ready_after"}, o.after_ready, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got no summary, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[7];
    obs_t        o, e;
    bit          chk;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [31:0] alu, sd, rdata;
    logic [4:0]  rd;
    logic        wbr;
    int          k, ack_at;

    vecs[0] = '{7'h33, 3'd0, 1'b1, 5'd5, 32'h12345678, 1'b1, 32'h12345678, 1'b0};
    vecs[1] = '{7'h13, 3'd0, 1'b0, 5'd7, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{7'h37, 3'd0, 1'b1, 5'd0, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 1'b0};
    vecs[3] = '{OP_LOAD, 3'd2, 1'b1, 5'd9, 32'h00000006, 1'b0, 32'h0, 1'b1};
    vecs[4] = '{OP_STORE, 3'd1, 1'b0, 5'd0, 32'h00000023, 1'b0, 32'h0, 1'b1};
    vecs[5] = '{OP_LOAD, 3'd3, 1'b1, 5'd4, 32'h00000100, 1'b0, 32'h0, 1'b1};
    vecs[6] = '{OP_LOAD, 3'd5, 1'b1, 5'd4, 32'h00000041, 1'b0, 32'h0, 1'b1};

    // Reset holds everything at zero even with an operation offered and clocks running.
    rst = 1'b0; valid = 1'b1; opcode = OP_LOAD; func3 = 3'd2; wb_reg = 1'b1; rd_num = 5'd3;
    alu_out = 32'h100; store_data = 32'h55; dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    repeat (3) @(negedge clk);
    check("rst ready", ready, 1'b1);
    check("rst outputs", {dmem_req, dmem_we, wb_enable, done, misalign, timeout}, 6'b0);
    check("rst dmem_addr", dmem_addr, 32'h0);
    check("rst dmem_wdata", dmem_wdata, 32'h0);
    check("rst dmem_be", dmem_be, 4'h0);
    check("rst wb_rd_num", wb_rd_num, 5'h0);
    check("rst wb_rd_data", wb_rd_data, 32'h0);
    valid = 1'b0; dmem_ack = 1'b0;
    rst = 1'b1;

    // Table of operations that retire the cycle after acceptance.
    for (int i = 0; i < 7; i++) begin
      exec_op(vecs[i].opc, vecs[i].f3, vecs[i].wbr, vecs[i].rd, vecs[i].alu, 32'h0,
              1, $urandom, o);
      check($sformatf("vec%0d latency", i), o.latency, 1);
      check($sformatf("vec%0d req_cycles", i), o.req_cycles, 0);
      check($sformatf("vec%0d done", i), o.done, 1'b1);
      check($sformatf("vec%0d wb_enable", i), o.wb_en, vecs[i].exp_wb);
      check($sformatf("vec%0d wb_rd_num", i), o.wb_num, vecs[i].rd);
      check($sformatf("vec%0d misalign", i), o.mis, vecs[i].exp_mis);
      check($sformatf("vec%0d timeout", i), o.to, 1'b0);
      if (vecs[i].exp_wb) check($sformatf("vec%0d wb_rd_data", i), o.wb_data, vecs[i].exp_data);
    end

    // LB at 0x103, two wait cycles before the ack.
    exec_op(OP_LOAD, 3'd0, 1'b1, 5'd8, 32'h103, 32'h0, 3, 32'h80FF7F01, o);
    check("lb dmem_addr", o.addr, 32'h100);
    check("lb dmem_be", o.be, 4'b1111);
    check("lb wb_rd_data", o.wb_data, 32'hFFFFFF80);
    check("lb wb_enable", o.wb_en, 1'b1);
    check("lb latency", o.latency, 4);

    // SH at 0x22.
    exec_op(OP_STORE, 3'd1, 1'b1, 5'd6, 32'h22, 32'hAAAABEEF, 1, 32'h0, o);
    check("sh dmem_we", o.we, 1'b1);
    check("sh dmem_be", o.be, 4'b1100);
    check("sh dmem_wdata", o.wdata, 32'hBEEFBEEF);
    check("sh dmem_addr", o.addr, 32'h20);
    check("sh wb_enable", o.wb_en, 1'b0);
    check("sh latency", o.latency, 2);

    // LW with no ack: timeout after exactly MAX_WAIT request cycles.
    exec_op(OP_LOAD, 3'd2, 1'b1, 5'd10, 32'h40, 32'h0, 0, 32'h0, o);
    check("lw_to req_cycles", o.req_cycles, 16);
    check("lw_to timeout", o.to, 1'b1);
    check("lw_to done", o.done, 1'b1);
    check("lw_to wb_enable", o.wb_en, 1'b0);
    check("lw_to latency", o.latency, 17);

    // LW with the ack on the last allowed cycle: the ack wins.
    exec_op(OP_LOAD, 3'd2, 1'b1, 5'd10, 32'h40, 32'h0, 16, 32'h13579BDF, o);
    check("lw_last req_cycles", o.req_cycles, 16);
    check("lw_last timeout", o.to, 1'b0);
    check("lw_last wb_enable", o.wb_en, 1'b1);
    check("lw_last wb_rd_data", o.wb_data, 32'h13579BDF);

    // Reset asserted mid-access drops the request at once and abandons the operation.
    @(negedge clk);
    valid = 1'b1; opcode = OP_LOAD; func3 = 3'd2; rd_num = 5'd3; alu_out = 32'h80;
    dmem_ack = 1'b0;
    @(negedge clk);
    valid = 1'b0;
    check("rstmid req_before", dmem_req, 1'b1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rstmid req_dropped", dmem_req, 1'b0);
    check("rstmid ready", ready, 1'b1);
    check("rstmid done", done, 1'b0);
    check("rstmid dmem_addr", dmem_addr, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rstmid no_done", done, 1'b0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("rstmid ready_after", ready, 1'b1);
    check("rstmid no_done_after", done, 1'b0);
    exec_op(OP_LOAD, 3'd5, 1'b1, 5'd12, 32'h42, 32'h0, 1, 32'hFFFE0000, o);
    check("lhu wb_rd_data", o.wb_data, 32'h0000FFFE);
    check("lhu dmem_addr", o.addr, 32'h40);
    check("lhu wb_enable", o.wb_en, 1'b1);

    // Randomized operations against the reference model, with stray acks outside the access.
    ack_noise = 1'b1;
    for (int i = 0; i < 150; i++) begin
      k      = $urandom_range(0, 9);
      opc    = (k < 4) ? OP_LOAD : (k < 8) ? OP_STORE : 7'($urandom);
      f3     = 3'($urandom);
      wbr    = 1'($urandom);
      rd     = 5'($urandom);
      alu    = $urandom;
      sd     = $urandom;
      rdata  = $urandom;
      ack_at = $urandom_range(0, 18);
      if ($urandom_range(0, 1) == 1) alu[1:0] = 2'b00;
      exec_op(opc, f3, wbr, rd, alu, sd, ack_at, rdata, o);
      model(opc, f3, wbr, rd, alu, sd, ack_at, rdata, e, chk);
      compare($sformatf("rnd%0d", i), o, e, chk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter MAX_WAIT, default 16: the most cycles dmem_req is held waiting for dmem_ack before timing out (range 1-255).
REQ-002 The block SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1: reset; asynchronous, active-low.
REQ-004 The block SHALL have the following upstream ports from decode_execute:
- valid  input  1: operation present.
- opcode  input  7: instruction opcode.
- func3  input  3: instruction func3.
- wb_reg  input  1: operation writes rd.
- rd_num  input  5: destination register number.
- alu_out  input  32: result or effective address.
- store_data  input  32: rs2 value.
REQ-005 The block SHALL have port ready  output  1: block can accept an operation this cycle.
REQ-006 The block SHALL have the following data memory ports:
- dmem_req  output  1: request.
- dmem_we  output  1: write request.
- dmem_addr  output  32: word address, bits [1:0] = 0.
- dmem_wdata  output  32: write data.
- dmem_be  output  4: byte enables.
- dmem_ack  input  1: request completed.
- dmem_rdata  input  32: read word.
REQ-007 The block SHALL have the following register file ports:
- wb_enable  output  1: write register file.
- wb_rd_num  output  5: register written.
- wb_rd_data  output  32: data written.
REQ-008 The block SHALL have the following controller ports:
- done  output  1: one-cycle pulse, operation retired.
- misalign  output  1: qualifies done; misaligned access.
- timeout  output  1: qualifies done; memory did not ack.

Function
REQ-009 The FSM SHALL have states IDLE, MEM and RETIRE; ready SHALL be 1 only in IDLE.
REQ-010 An operation SHALL be accepted on a rising edge with valid=1 and ready=1; all inputs SHALL be captured at acceptance and later input changes ignored.
REQ-011 Opcode classes SHALL be: LOAD 0000011, STORE 0100011, anything else non-memory.
REQ-012 A non-memory operation SHALL go IDLE->RETIRE, and in the cycle after acceptance assert done=1 and wb_enable=wb_reg, with wb_rd_data=alu_out.
REQ-013 Alignment SHALL be checked at acceptance:
- func3[1:0]=01 requires addr[0]=0.
- func3[1:0]=10 requires addr[1:0]=00.
- func3[1:0]=11 is illegal and treated as misaligned.
REQ-014 A misaligned memory operation SHALL go to RETIRE with no dmem_req, then pulse done=1 and misalign=1 with wb_enable=0.
REQ-015 An aligned memory operation SHALL go to MEM, and dmem_req SHALL be asserted from the cycle after acceptance and held with stable addr, we, be and wdata until dmem_ack=1 is sampled.
REQ-016 dmem_addr SHALL be {addr[31:2],2'b00}, and dmem_we SHALL be 1 for STORE and 0 for LOAD.
REQ-017 Store byte enables and write data SHALL follow the access size:
- SB: dmem_be=0001<<addr[1:0]; the store_data byte is replicated to all 4 lanes.
- SH: dmem_be=0011<<addr[1:0]; the halfword is replicated to both halves.
- SW: dmem_be=1111; the full word is written.
- Loads: dmem_be=1111.
REQ-018 On a sampled dmem_ack, the block SHALL drop dmem_req in the same edge's next cycle and enter RETIRE.
REQ-019 Load data SHALL be the dmem_rdata lane selected by addr[1:0], extended by func3:
- LB: sign-extended byte.
- LBU: zero-extended byte.
- LH: sign-extended halfword.
- LHU: zero-extended halfword.
- LW: word.
REQ-020 In RETIRE the block SHALL pulse done=1; for a LOAD it SHALL assert wb_enable=1 with the extended data; for a STORE it SHALL keep wb_enable=0.
REQ-021 wb_enable SHALL be forced to 0 whenever wb_rd_num=0.
REQ-022 A wait counter SHALL count dmem_req cycles without ack; if it reaches MAX_WAIT, the block SHALL drop dmem_req, enter RETIRE, and pulse done=1 and timeout=1 with wb_enable=0.
REQ-023 An ack arriving in the same cycle that the count reaches MAX_WAIT SHALL win, with no timeout flagged.
REQ-024 RETIRE SHALL always return to IDLE next cycle, giving minimum latencies of 1 cycle for non-memory operations and 2 cycles for a zero-wait memory operation, from acceptance to done.
REQ-025 dmem_ack sampled outside MEM SHALL be ignored.

Reset
REQ-026 While rst=0, the FSM SHALL be IDLE with counter 0, and ready=1.
REQ-027 While rst=0, all other outputs SHALL be 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, wb_enable, wb_rd_num, wb_rd_data, done, misalign and timeout.
REQ-028 Reset asserted mid-MEM SHALL drop dmem_req immediately (asynchronously) and abandon the operation with no done.

Verification
REQ-029 The bench SHALL cover: non-memory op with alu_out=0x12345678, rd=5, wb_reg=1 -> next cycle wb_enable=1, wb_rd_num=5, data 0x12345678, done=1.
REQ-030 The bench SHALL cover: LB at addr 0x103 with dmem_rdata=0x80FF7F01 and ack after 2 cycles -> dmem_addr=0x100, be=1111, wb_rd_data=0xFFFFFF80, done one cycle after ack.
REQ-031 The bench SHALL cover: SH at addr 0x22 with store_data=0xAAAABEEF -> dmem_we=1, be=1100, wdata=0xBEEFBEEF, wb_enable=0, done after ack.
REQ-032 The bench SHALL cover: LW at addr 0x06 -> no dmem_req, next cycle done=1, misalign=1, wb_enable=0.
REQ-033 The bench SHALL cover: LW with MAX_WAIT=16 and no ack -> dmem_req high exactly 16 cycles, then done=1, timeout=1; a second case with ack on the 16th cycle -> normal writeback, timeout=0.
REQ-034 The bench SHALL cover: rst driven low during MEM -> dmem_req low within the same cycle; after release ready=1 and the next LHU at 0x42 with rdata=0xFFFE0000 gives wb_rd_data=0x0000FFFE.
